// File: rtl/uart_ctrl_pkg.sv
// Shared constants and state encoding for the UART register-bus sequencer.
// Register map and LSR bit positions follow the 16550 layout.
package uart_ctrl_pkg;

    localparam logic [2:0] REG_THR = 3'd0;
    localparam logic [2:0] REG_DLL = 3'd0;
    localparam logic [2:0] REG_IER = 3'd1;
    localparam logic [2:0] REG_DLM = 3'd1;
    localparam logic [2:0] REG_FCR = 3'd2;
    localparam logic [2:0] REG_LCR = 3'd3;
    localparam logic [2:0] REG_LSR = 3'd5;

    localparam int LSR_THRE = 5;
    localparam int LSR_TEMT = 6;

    localparam logic [7:0] FCR_INIT = 8'h07;
    localparam logic [7:0] LCR_DLAB = 8'h80;

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_CFG_DLAB  = 4'd1,
        S_CFG_DLL   = 4'd2,
        S_CFG_DLM   = 4'd3,
        S_CFG_LCR   = 4'd4,
        S_CFG_FCR   = 4'd5,
        S_THRE_RD   = 4'd6,
        S_THRE_CHK  = 4'd7,
        S_THRE_WAIT = 4'd8,
        S_MEM_RD    = 4'd9,
        S_MEM_WAIT  = 4'd10,
        S_THR_WR    = 4'd11,
        S_TEMT_RD   = 4'd12,
        S_TEMT_CHK  = 4'd13,
        S_TEMT_WAIT = 4'd14,
        S_DONE      = 4'd15
    } state_e;

endpackage

// File: rtl/uart_poll_timer.sv
// Down-counter that spaces LSR polls: load on a failed check, expire after GAP enabled cycles.
// A single instance serves both the THRE and the TEMT poll loops.
module uart_poll_timer #(
    parameter int GAP = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic load_i,
    input  logic en_i,
    output logic expire_o
);

    localparam int CW = (GAP > 1) ? $clog2(GAP) : 1;

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next count: reload, count down while enabled, otherwise hold
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = CW'(GAP - 1);
        end else if (en_i && (cnt_q != {CW{1'b0}})) begin
            cnt_d = cnt_q - CW'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= {CW{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = (cnt_q == {CW{1'b0}});

endmodule

// File: rtl/uart_mem_tx_sched.sv
// Sole master of the 16550 register bus: programs the line, then streams a RAM
// buffer into THR in FIFO-sized bursts paced by LSR polling, and pulses done on TEMT.
module uart_mem_tx_sched
    import uart_ctrl_pkg::*;
#(
    parameter int ADDR_W     = 10,
    parameter int FIFO_DEPTH = 16,
    parameter int POLL_GAP   = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] base_addr_i,
    input  logic [ADDR_W:0]   len_i,
    input  logic [15:0]       cfg_div_i,
    input  logic [7:0]        cfg_lcr_i,
    output logic              mem_rd_en_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic [7:0]        mem_rdata_i,
    output logic              uart_wr_o,
    output logic              uart_rd_o,
    output logic [2:0]        uart_addr_o,
    output logic [7:0]        uart_din_o,
    input  logic [7:0]        uart_dout_i,
    output logic              busy_o,
    output logic              done_o
);

    localparam int LEN_W = ADDR_W + 1;
    localparam int BC_W  = $clog2(FIFO_DEPTH + 1);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   ptr_q, ptr_d;
    logic [LEN_W-1:0]    rem_q, rem_d;
    logic [BC_W-1:0]     bcnt_q, bcnt_d;
    logic [15:0]         div_q, div_d;
    logic [7:0]          lcr_q, lcr_d;

    logic                mem_rd_en_q, mem_rd_en_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic                uart_wr_q, uart_wr_d;
    logic                uart_rd_q, uart_rd_d;
    logic [2:0]          uart_addr_q, uart_addr_d;
    logic [7:0]          uart_din_q, uart_din_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic                timer_load_s;
    logic                timer_en_s;
    logic                timer_expire_s;

    function automatic logic [BC_W-1:0] burst_len(input logic [LEN_W-1:0] rem);
        if (rem > LEN_W'(FIFO_DEPTH)) begin
            burst_len = BC_W'(FIFO_DEPTH);
        end else begin
            burst_len = BC_W'(rem);
        end
    endfunction

    assign timer_load_s = ((state_q == S_THRE_CHK) && !uart_dout_i[LSR_THRE]) ||
                          ((state_q == S_TEMT_CHK) && !uart_dout_i[LSR_TEMT]);
    assign timer_en_s   = (state_q == S_THRE_WAIT) || (state_q == S_TEMT_WAIT);

    uart_poll_timer #(.GAP(POLL_GAP)) u_poll_timer (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .load_i   (timer_load_s),
        .en_i     (timer_en_s),
        .expire_o (timer_expire_s)
    );

    // State and job-context registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            ptr_q   <= {ADDR_W{1'b0}};
            rem_q   <= {LEN_W{1'b0}};
            bcnt_q  <= {BC_W{1'b0}};
            div_q   <= 16'h0000;
            lcr_q   <= 8'h00;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            rem_q   <= rem_d;
            bcnt_q  <= bcnt_d;
            div_q   <= div_d;
            lcr_q   <= lcr_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = (len_i != {LEN_W{1'b0}}) ? S_CFG_DLAB : S_DONE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CFG_DLAB:  state_d = S_CFG_DLL;
            S_CFG_DLL:   state_d = S_CFG_DLM;
            S_CFG_DLM:   state_d = S_CFG_LCR;
            S_CFG_LCR:   state_d = S_CFG_FCR;
            S_CFG_FCR:   state_d = S_THRE_RD;
            S_THRE_RD:   state_d = S_THRE_CHK;
            S_THRE_CHK:  state_d = uart_dout_i[LSR_THRE] ? S_MEM_RD : S_THRE_WAIT;
            S_THRE_WAIT: state_d = timer_expire_s ? S_THRE_RD : S_THRE_WAIT;
            S_MEM_RD:    state_d = S_MEM_WAIT;
            S_MEM_WAIT:  state_d = S_THR_WR;
            S_THR_WR: begin
                if (bcnt_q == BC_W'(1)) begin
                    state_d = (rem_q == LEN_W'(1)) ? S_TEMT_RD : S_THRE_RD;
                end else begin
                    state_d = S_MEM_RD;
                end
            end
            S_TEMT_RD:   state_d = S_TEMT_CHK;
            S_TEMT_CHK:  state_d = uart_dout_i[LSR_TEMT] ? S_DONE : S_TEMT_WAIT;
            S_TEMT_WAIT: state_d = timer_expire_s ? S_TEMT_RD : S_TEMT_WAIT;
            S_DONE:      state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase
    end

    // Job context: captured on accepted start, advanced on each THR write
    always_comb begin
        ptr_d  = ptr_q;
        rem_d  = rem_q;
        bcnt_d = bcnt_q;
        div_d  = div_q;
        lcr_d  = lcr_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    ptr_d = base_addr_i;
                    rem_d = len_i;
                    div_d = cfg_div_i;
                    lcr_d = cfg_lcr_i & ~LCR_DLAB;
                end else begin
                    ptr_d = ptr_q;
                end
            end
            S_THRE_CHK: begin
                if (uart_dout_i[LSR_THRE]) begin
                    bcnt_d = burst_len(rem_q);
                end else begin
                    bcnt_d = bcnt_q;
                end
            end
            S_THR_WR: begin
                ptr_d  = ptr_q + ADDR_W'(1);
                rem_d  = rem_q - LEN_W'(1);
                bcnt_d = bcnt_q - BC_W'(1);
            end
            default: begin
                ptr_d = ptr_q;
            end
        endcase
    end

    // Output decode from the upcoming state so every bus output leaves a flop
    always_comb begin
        mem_rd_en_d = 1'b0;
        mem_addr_d  = {ADDR_W{1'b0}};
        uart_wr_d   = 1'b0;
        uart_rd_d   = 1'b0;
        uart_addr_d = 3'd0;
        uart_din_d  = 8'h00;
        done_d      = 1'b0;
        busy_d      = (state_d != S_IDLE) && (state_d != S_DONE);
        case (state_d)
            S_CFG_DLAB: begin uart_wr_d = 1'b1; uart_addr_d = REG_LCR; uart_din_d = LCR_DLAB;    end
            S_CFG_DLL:  begin uart_wr_d = 1'b1; uart_addr_d = REG_DLL; uart_din_d = div_q[7:0];  end
            S_CFG_DLM:  begin uart_wr_d = 1'b1; uart_addr_d = REG_DLM; uart_din_d = div_q[15:8]; end
            S_CFG_LCR:  begin uart_wr_d = 1'b1; uart_addr_d = REG_LCR; uart_din_d = lcr_q;       end
            S_CFG_FCR:  begin uart_wr_d = 1'b1; uart_addr_d = REG_FCR; uart_din_d = FCR_INIT;    end
            S_THRE_RD, S_TEMT_RD: begin
                uart_rd_d   = 1'b1;
                uart_addr_d = REG_LSR;
            end
            S_MEM_RD: begin
                mem_rd_en_d = 1'b1;
                mem_addr_d  = ptr_d;
            end
            S_THR_WR: begin
                uart_wr_d   = 1'b1;
                uart_addr_d = REG_THR;
                uart_din_d  = mem_rdata_i;
            end
            S_DONE:  done_d = 1'b1;
            default: done_d = 1'b0;
        endcase
    end

    // Output registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mem_rd_en_q <= 1'b0;
            mem_addr_q  <= {ADDR_W{1'b0}};
            uart_wr_q   <= 1'b0;
            uart_rd_q   <= 1'b0;
            uart_addr_q <= 3'd0;
            uart_din_q  <= 8'h00;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            mem_rd_en_q <= mem_rd_en_d;
            mem_addr_q  <= mem_addr_d;
            uart_wr_q   <= uart_wr_d;
            uart_rd_q   <= uart_rd_d;
            uart_addr_q <= uart_addr_d;
            uart_din_q  <= uart_din_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign mem_rd_en_o = mem_rd_en_q;
    assign mem_addr_o  = mem_addr_q;
    assign uart_wr_o   = uart_wr_q;
    assign uart_rd_o   = uart_rd_q;
    assign uart_addr_o = uart_addr_q;
    assign uart_din_o  = uart_din_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;

endmodule
